// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared UART definitions for the transmit and receive paths
//   uart_state_t  : frame FSM states (IDLE, START, DATA, STOP)
//   DATA_BITS     : payload bits per frame
//   clks_per_bit  : system clocks per serial bit for a given clock and line rate
package uart_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } uart_state_t;

    localparam int DATA_BITS = 8;

    // Integer division; callers must pick rates that give a result >= 2.
    function automatic int clks_per_bit(input int freq, input int baud);
        return freq / baud;
    endfunction

endpackage

// File: rtl/uart_baud_gen.sv
// rtl/uart_baud_gen.sv - bit-period counter for the UART frame FSM
//   clk     in  system clock
//   rst     in  synchronous active-low reset
//   clear   in  hold the counter at 0 (used while the line is idle)
//   bit_end out high on the last cycle of each bit period
module uart_baud_gen #(
    parameter int CLKS_PER_BIT = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    output logic bit_end
);

    localparam int                CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CNT_W-1:0]  LAST  = CNT_W'(CLKS_PER_BIT - 1);

    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk) begin
        if (!rst) begin
            cnt <= '0;
        end else if (clear || (cnt == LAST)) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + CNT_W'(1);
        end
    end

    // Suppressed while cleared so an idle line never reports a bit boundary.
    assign bit_end = !clear && (cnt == LAST);

endmodule

// File: rtl/uart_tx_byte.sv
// rtl/uart_tx_byte.sv - 8N1 UART transmitter, one byte per start/ready handshake
//   clk       in   system clock
//   rst       in   synchronous active-low reset; aborts a frame in progress
//   tx_start  in   send request, honoured only while tx_ready=1
//   tx_data   in   byte to send, captured in the accept cycle
//   tx_ready  out  idle and able to accept tx_start this cycle
//   tx_done   out  registered one-cycle pulse after the stop bit completes
//   tx        out  registered serial line, idles high
module uart_tx_byte
    import uart_pkg::*;
#(
    parameter int CLK_FREQ  = 100_000_000,
    parameter int BAUD_RATE = 9600
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       tx_start,
    input  logic [7:0] tx_data,
    output logic       tx_ready,
    output logic       tx_done,
    output logic       tx
);

    localparam int         CLKS_PER_BIT = clks_per_bit(CLK_FREQ, BAUD_RATE);
    localparam logic [2:0] LAST_BIT     = 3'(DATA_BITS - 1);

    uart_state_t state;
    logic [2:0]  bit_idx;
    logic [7:0]  shreg;
    logic        bit_end;

    // The counter is held at 0 while idle, so the start bit gets a full
    // period starting the cycle after the accept edge.
    uart_baud_gen #(
        .CLKS_PER_BIT (CLKS_PER_BIT)
    ) u_baud_gen (
        .clk     (clk),
        .rst     (rst),
        .clear   (state == IDLE),
        .bit_end (bit_end)
    );

    assign tx_ready = (state == IDLE);

    // tx is loaded together with each state change so the line value always
    // lines up with the bit period that the state describes.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state   <= IDLE;
            tx      <= 1'b1;
            tx_done <= 1'b0;
            bit_idx <= '0;
            shreg   <= '0;
        end else begin
            tx_done <= 1'b0;
            case (state)
                IDLE: begin
                    tx <= 1'b1;
                    if (tx_start) begin
                        shreg   <= tx_data;
                        bit_idx <= '0;
                        tx      <= 1'b0;
                        state   <= START;
                    end
                end
                START: begin
                    if (bit_end) begin
                        bit_idx <= '0;
                        tx      <= shreg[0];
                        state   <= DATA;
                    end
                end
                DATA: begin
                    if (bit_end) begin
                        shreg <= shreg >> 1;
                        if (bit_idx == LAST_BIT) begin
                            bit_idx <= '0;
                            tx      <= 1'b1;
                            state   <= STOP;
                        end else begin
                            bit_idx <= bit_idx + 3'd1;
                            tx      <= shreg[1];
                        end
                    end
                end
                STOP: begin
                    tx <= 1'b1;
                    if (bit_end) begin
                        tx_done <= 1'b1;
                        state   <= IDLE;
                    end
                end
                default: begin
                    tx    <= 1'b1;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
